// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte width, ACK/NACK levels and the FSM state
// encodings that both the target and the master debug decoders use.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [3:0] I2C_ST_IDLE     = 4'd0;
    localparam logic [3:0] I2C_ST_ADDR     = 4'd1;
    localparam logic [3:0] I2C_ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] I2C_ST_WR_DATA  = 4'd3;
    localparam logic [3:0] I2C_ST_WR_ACK   = 4'd4;
    localparam logic [3:0] I2C_ST_RD_DATA  = 4'd5;
    localparam logic [3:0] I2C_ST_RD_ACK   = 4'd6;
    localparam logic [3:0] I2C_ST_IGNORE   = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE     = I2C_ST_IDLE,
        ST_ADDR     = I2C_ST_ADDR,
        ST_ADDR_ACK = I2C_ST_ADDR_ACK,
        ST_WR_DATA  = I2C_ST_WR_DATA,
        ST_WR_ACK   = I2C_ST_WR_ACK,
        ST_RD_DATA  = I2C_ST_RD_DATA,
        ST_RD_ACK   = I2C_ST_RD_ACK,
        ST_IGNORE   = I2C_ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus-side and parallel-side signals of the I2C target, grouped so the
// target and its peer/bench connect through one port.
interface i2c_slave_if;
    import i2c_pkg::*;

    logic                  scl;
    logic                  sda_in;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_req;
    logic                  busy;
    logic [3:0]            state;
    logic [3:0]            count;

    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, state, count
    );

    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, state, count
    );

endinterface

// File: rtl/i2c_line_filter.sv
// SCL/SDA conditioning: 2-FF synchronizer, optional 3-sample majority
// filter (I2C_SLAVE_GLITCH_FILTER_EN), registered edge and START/STOP flags.
// Raw pin edge to flag: 3 clk, or 5 clk with the filter.
module i2c_line_filter (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    logic [1:0] raw;
    logic [1:0] cond;

    assign raw = {sda_i, scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic s1_q, s2_q;

            // Two-stage synchronizer; idle bus level is high.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_q <= 1'b1;
                    s2_q <= 1'b1;
                end else begin
                    s1_q <= raw[gi];
                    s2_q <= s1_q;
                end
            end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
            logic h0_q, h1_q, maj_q;

            // Majority of three consecutive samples hides 1-clk pulses.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    h0_q  <= 1'b1;
                    h1_q  <= 1'b1;
                    maj_q <= 1'b1;
                end else begin
                    h0_q  <= s2_q;
                    h1_q  <= h0_q;
                    maj_q <= (s2_q & h0_q) | (s2_q & h1_q) | (h0_q & h1_q);
                end
            end

            assign cond[gi] = maj_q;
`else
            assign cond[gi] = s2_q;
`endif
        end
    endgenerate

    logic scl_prev_q, sda_prev_q;
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

    // Edge detect; START/STOP need SCL high both before and after the SDA
    // edge, so an SDA edge coinciding with an SCL edge raises no flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_prev_q <= cond[0];
            sda_prev_q <= cond[1];
            scl_rise_q <= cond[0] & ~scl_prev_q;
            scl_fall_q <= ~cond[0] & scl_prev_q;
            start_q    <= scl_prev_q & cond[0] & sda_prev_q & ~cond[1];
            stop_q     <= scl_prev_q & cond[0] & ~sda_prev_q & cond[1];
            sda_q      <= cond[1];
        end
    end

    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match with ACK, strobed write-byte port and
// request/load read-byte port. Optional input glitch filter is selected
// with I2C_SLAVE_GLITCH_FILTER_EN (handled in i2c_line_filter).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    i2c_slave_if.slave  bus
);

    logic scl_rise, scl_fall, start_evt, stop_evt, sda_lvl;

    i2c_line_filter u_filter (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (bus.scl),
        .sda_i      (bus.sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_evt),
        .stop_o     (stop_evt),
        .sda_o      (sda_lvl)
    );

    i2c_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rw_q, rw_d;
    logic                  phase_q, phase_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  busy_q, busy_d;
    logic [I2C_BYTE_W-1:0] shift_in;

    assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

    // State register; reset releases SDA immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic. phase_q marks the second half of an ACK slot
    // (ACK driven, or master ACK sampled). A read byte is loaded in the
    // cycle tx_req is high, and its MSB is driven from that load.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;

        if (start_evt) begin
            state_d  = ST_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (stop_evt) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = shift_in[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 4'd0;
                            if (!rw_q) begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_WR_DATA;
                            end else begin
                                tx_req_d = 1'b1;
                                state_d  = ST_RD_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (tx_req_q) begin
                        tx_shift_d = bus.tx_data;
                        sda_oe_d   = ~bus.tx_data[7];
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        cnt_d    = 4'd0;
                        tx_req_d = 1'b1;
                        state_d  = ST_RD_DATA;
                    end
                end
                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;
    assign bus.count    = cnt_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, table of transactions, and
// hand-written repeated-START, reset and glitch sequences.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_slave_if bus ();

    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int rxv_cnt = 0;
    int exp_rxv = 0;
    int txr_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] rd_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Scoreboard side for writes: each rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (reset && bus.rx_valid) begin
            rxv_cnt++;
            check("rx_valid_count", rxv_cnt, exp_rxv);
            if (rx_q.size() > 0) check("rx_data", bus.rx_data, rx_q.pop_front());
        end
        if (reset && bus.tx_req) txr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        wq(); sda_m = 1'b1;
        wq(); scl_m = 1'b1;
        wq(); sda_m = 1'b0;
        wq(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wq(); sda_m = 1'b0;
        wq(); scl_m = 1'b1;
        wq(); sda_m = 1'b1;
        wq();
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        wq(); sda_m = b;
        wq(); scl_m = 1'b1;
        wq(); r = bus.sda_in;
        wq(); scl_m = 1'b0;
    endtask

    task automatic byte_write(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic byte_read(input logic nack, input logic [7:0] nxt, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bus.tx_data = nxt;
        bit_xfer(nack, r);
    endtask

    typedef struct {
        string      nm;
        logic [6:0] addr;
        logic       rw;
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       exp_ack;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic       a;
        logic       r;
        logic [7:0] d;
        int         rxv0, txr0;

        vt[0] = '{"wr_50_AA",   7'h50, 1'b0, 1, 8'hAA, 8'h00, 1'b1};
        vt[1] = '{"wr_51_CC",   7'h51, 1'b0, 1, 8'hCC, 8'h00, 1'b0};
        vt[2] = '{"rd_50_F00F", 7'h50, 1'b1, 2, 8'hF0, 8'h0F, 1'b1};
        vt[3] = '{"wr_gcall",   7'h00, 1'b0, 1, 8'h11, 8'h00, 1'b0};
        vt[4] = '{"wr_50_5A3C", 7'h50, 1'b0, 2, 8'h5A, 8'h3C, 1'b1};
        vt[5] = '{"rd_2A",      7'h2A, 1'b1, 1, 8'h81, 8'h00, 1'b0};

        bus.tx_data = 8'h00;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sda_oe",   bus.sda_oe,   0);
        check("rst_rx_data",  bus.rx_data,  0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_req",   bus.tx_req,   0);
        check("rst_busy",     bus.busy,     0);
        check("rst_state",    bus.state,    I2C_ST_IDLE);
        check("rst_count",    bus.count,    0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Table of transactions
        for (int i = 0; i < 6; i++) begin
            rxv0 = rxv_cnt;
            txr0 = txr_cnt;
            $display("-- vector %s", vt[i].nm);
            if (vt[i].rw) begin
                bus.tx_data = vt[i].b0;
                if (vt[i].exp_ack) rd_q.push_back(vt[i].b0);
            end
            bus_start();
            byte_write({vt[i].addr, vt[i].rw}, a);
            check("addr_ack", a, vt[i].exp_ack ? 0 : 1);
            check("busy_after_addr", bus.busy, vt[i].exp_ack);
            if (!vt[i].exp_ack) check("state_ignore", bus.state, I2C_ST_IGNORE);
            for (int k = 0; k < vt[i].nb; k++) begin
                logic [7:0] bd;
                bd = (k == 0) ? vt[i].b0 : vt[i].b1;
                if (!vt[i].rw) begin
                    if (vt[i].exp_ack) begin
                        rx_q.push_back(bd);
                        exp_rxv++;
                    end
                    byte_write(bd, a);
                    check("data_ack", a, vt[i].exp_ack ? 0 : 1);
                end else begin
                    if (vt[i].exp_ack && k < vt[i].nb - 1) rd_q.push_back(vt[i].b1);
                    byte_read(k == vt[i].nb - 1, vt[i].b1, d);
                    if (vt[i].exp_ack) check("rd_byte", d, rd_q.pop_front());
                    else               check("rd_released", d, 8'hFF);
                end
                if (!vt[i].exp_ack) check("state_ignore", bus.state, I2C_ST_IGNORE);
            end
            if (vt[i].rw && vt[i].exp_ack) check("state_after_nack", bus.state, I2C_ST_IGNORE);
            bus_stop();
            check("state_idle", bus.state, I2C_ST_IDLE);
            check("busy_stop",  bus.busy,  0);
            check("rx_valid_pulses", rxv_cnt - rxv0, (!vt[i].rw && vt[i].exp_ack) ? vt[i].nb : 0);
            check("tx_req_pulses",   txr_cnt - txr0, (vt[i].rw && vt[i].exp_ack) ? vt[i].nb : 0);
        end

        // Repeated START after 4 bits of a write byte
        $display("-- repeated start");
        rxv0 = rxv_cnt;
        bus_start();
        byte_write({7'h50, 1'b0}, a);
        check("rs_addr_ack", a, 0);
        bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
        bus_start();
        check("rs_state", bus.state, I2C_ST_ADDR);
        check("rs_count", bus.count, 0);
        check("rs_busy",  bus.busy,  0);
        bus.tx_data = 8'hA5;
        rd_q.push_back(8'hA5);
        byte_write({7'h50, 1'b1}, a);
        check("rs_rd_ack", a, 0);
        check("rs_busy_match", bus.busy, 1);
        byte_read(1'b1, 8'h00, d);
        check("rs_rd_byte", d, rd_q.pop_front());
        bus_stop();
        check("rs_no_rx_valid", rxv_cnt - rxv0, 0);

        // Reset while the target drives read bit 0
        $display("-- reset mid-read");
        bus.tx_data = 8'h00;
        bus_start();
        byte_write({7'h50, 1'b1}, a);
        check("mr_addr_ack", a, 0);
        for (int k = 0; k < 7; k++) bit_xfer(1'b1, r);
        repeat (8) @(negedge clk);
        check("mr_bit0_driven", bus.sda_oe, 1);
        #2 reset = 1'b0;
        #1;
        check("mr_sda_oe",   bus.sda_oe,   0);
        check("mr_state",    bus.state,    I2C_ST_IDLE);
        check("mr_busy",     bus.busy,     0);
        check("mr_count",    bus.count,    0);
        check("mr_rx_data",  bus.rx_data,  0);
        check("mr_rx_valid", bus.rx_valid, 0);
        check("mr_tx_req",   bus.tx_req,   0);
        @(negedge clk);
        reset = 1'b1;
        bus_stop();

        // 1-clk SDA glitch low while SCL is high during a '1' data bit
        $display("-- sda glitch");
        bus_start();
        byte_write({7'h50, 1'b0}, a);
        check("gl_addr_ack", a, 0);
        wq(); sda_m = 1'b1;
        wq(); scl_m = 1'b1;
        repeat (4) @(negedge clk);
        sda_m = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        repeat (8) @(negedge clk);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("gl_state_kept", bus.state, I2C_ST_WR_DATA);
        check("gl_count",      bus.count, 1);
`else
        check("gl_state_idle", bus.state, I2C_ST_IDLE);
        check("gl_busy",       bus.busy,  0);
`endif
        wq(); scl_m = 1'b0;
        bus_stop();
        check("gl_state_end", bus.state, I2C_ST_IDLE);

        check("rx_q_drained", rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
